hex_display_scanner: RTL

Parametrised multiplexed seven-segment display driver, successor to the fixed two-word display path used for showing the fetch unit's instruction and PC on the board. It scans DIGITS common-anode digits from one of CHANNELS packed hex words. It can select the channel manually or rotate through channels automatically, and it captures a coherent per-frame snapshot so a value changing mid-scan never tears. It sits at top level between the datapath debug buses and the board's out7/en_out pins.

---
 rtl/hex_display_scanner_if.sv | 37 +++
 rtl/hex_display_scanner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if
// Bundles the debug words, channel-control inputs and the display pins of
// the seven-segment scanner.
//   data        : CHANNELS packed words, channel c digit d at [(c*DIGITS+d)*4 +: 4]
//   sel         : manual channel select (clamped by the scanner)
//   auto_rotate : 1 = rotate channels automatically, 0 = follow sel
//   freeze      : 1 = hold snapshot and channel at frame boundaries
//   out7        : segments, active-low, out7[0]=a .. out7[6]=g
//   en_out      : digit anodes, active-low
//   chan        : channel currently shown
//   frame_tick  : one-cycle pulse at each frame start
// Modports: master drives data/controls (datapath side), slave is the scanner.
interface hex_display_scanner_if #(
    parameter int DIGITS   = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*DIGITS*4-1:0] data;
    logic [SEL_W-1:0]             sel;
    logic                         auto_rotate;
    logic                         freeze;
    logic [6:0]                   out7;
    logic [DIGITS-1:0]            en_out;
    logic [SEL_W-1:0]             chan;
    logic                         frame_tick;

    modport master (
        output data, sel, auto_rotate, freeze,
        input  out7, en_out, chan, frame_tick
    );

    modport slave (
        input  data, sel, auto_rotate, freeze,
        output out7, en_out, chan, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Multiplexed seven-segment driver. Scans DIGITS common-anode digits from one
// of CHANNELS hex words, selected manually or by automatic rotation. The shown
// word is snapshotted at each frame boundary so mid-frame changes never tear.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : hex_display_scanner_if.slave (data/sel/auto_rotate/freeze in,
//         out7/en_out/chan/frame_tick out)
// Optional feature: define DISP_LZB_EN for leading-zero blanking (digits above
// the highest nonzero digit are dark; digit 0 always shown).
module hex_display_scanner #(
    parameter int DIGITS     = 8,
    parameter int CHANNELS   = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int ROT_FRAMES = 1000
) (
    input logic                    clk,
    input logic                    rst,
    hex_display_scanner_if.slave   bus
);
    localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int FC_W   = $clog2(ROT_FRAMES + 1);
    localparam int WORD_W = DIGITS * 4;

    logic [PRE_W-1:0]  prescaler;
    // Index of the digit to be shown at the next scan tick; a tick with
    // index 0 is therefore a frame boundary, including the first one.
    logic [DIG_W-1:0]  digit_idx;
    logic [FC_W-1:0]   frame_cnt;
    logic [SEL_W-1:0]  chan_q;
    logic [WORD_W-1:0] snapshot;
    logic [DIGITS-1:0] en_q;
    logic [6:0]        seg_q;
    logic              tick_q;

    logic              scan_tick;
    logic              boundary;
    logic [SEL_W-1:0]  sel_clamped;
    logic [SEL_W-1:0]  chan_next;
    logic [FC_W-1:0]   fc_next;
    logic [WORD_W-1:0] snap_next;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] en_next;
    logic [6:0]        seg_next;
    logic [WORD_W-1:0] words [CHANNELS];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_words
        assign words[c] = bus.data[c*WORD_W +: WORD_W];
    end

    assign scan_tick   = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign boundary    = scan_tick && (digit_idx == '0);
    assign sel_clamped = (bus.sel > SEL_W'(CHANNELS - 1)) ? SEL_W'(CHANNELS - 1) : bus.sel;

    // Channel, rotation counter and snapshot for the next cycle. The snapshot
    // follows the new channel in the same cycle so a switch starts at digit 0.
    always_comb begin
        chan_next = chan_q;
        fc_next   = frame_cnt;
        if (!bus.auto_rotate) begin
            fc_next = '0;
        end
        if (boundary && !bus.freeze) begin
            if (!bus.auto_rotate) begin
                chan_next = sel_clamped;
            end else if (frame_cnt == FC_W'(ROT_FRAMES - 1)) begin
                fc_next   = '0;
                chan_next = (chan_q == SEL_W'(CHANNELS - 1)) ? '0 : chan_q + SEL_W'(1);
            end else begin
                fc_next = frame_cnt + FC_W'(1);
            end
        end
        snap_next = (boundary && !bus.freeze) ? words[chan_next] : snapshot;
    end

    // Digit/segment pattern for the slot that starts after this tick.
    always_comb begin
        cur_digit = '0;
        en_next   = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (DIG_W'(d) == digit_idx) begin
                cur_digit  = snap_next[d*4 +: 4];
                en_next[d] = 1'b0;
            end
        end
        seg_next = hex_to_seg(cur_digit);
`ifdef DISP_LZB_EN
        begin : lzb
            logic [DIG_W-1:0] top_idx;
            top_idx = '0;
            for (int d = 0; d < DIGITS; d++) begin
                if (snap_next[d*4 +: 4] != 4'h0) begin
                    top_idx = DIG_W'(d);
                end
            end
            if (digit_idx > top_idx) begin
                en_next  = '1;
                seg_next = 7'b1111111;
            end
        end
`endif
    end

    // Prescaler, scan position, channel state and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
            chan_q    <= '0;
            snapshot  <= '0;
            en_q      <= '1;
            seg_q     <= 7'b1111111;
            tick_q    <= 1'b0;
        end else begin
            prescaler <= scan_tick ? '0 : prescaler + PRE_W'(1);
            frame_cnt <= fc_next;
            chan_q    <= chan_next;
            snapshot  <= snap_next;
            tick_q    <= boundary;
            if (scan_tick) begin
                digit_idx <= (digit_idx == DIG_W'(DIGITS - 1)) ? '0 : digit_idx + DIG_W'(1);
                en_q      <= en_next;
                seg_q     <= seg_next;
            end
        end
    end

    assign bus.out7       = seg_q;
    assign bus.en_out     = en_q;
    assign bus.chan       = chan_q;
    assign bus.frame_tick = tick_q;
endmodule
